// File: rtl/booth_digit_decoder.sv
// Rebuilds an N-bit two's-complement value from LSB-first radix-2 Booth digits.
// Result is valid one cycle after the last digit and is held until result_ack.
module booth_digit_decoder #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         digit_valid,
  input  logic [1:0]   digit,
  output logic         digit_ready,
  output logic [N-1:0] result,
  output logic         result_valid,
  input  logic         result_ack,
  output logic         error,
  output logic         busy
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_COLLECT = 2'd1;
  localparam logic [1:0] S_DONE    = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [N-1:0]  acc_q, acc_d;
  logic [IW-1:0] idx_q, idx_d;
  logic          error_q, error_d;
  logic [N-1:0]  weight;
  logic          last_digit;

  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    idx_d      = idx_q;
    error_d    = error_q;
    weight     = N'(1) << idx_q;
    last_digit = (idx_q == IW'(N - 1));

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_COLLECT;
          acc_d   = '0;
          idx_d   = '0;
          error_d = 1'b0;
        end
      end
      S_COLLECT: begin
        if (digit_valid) begin
          // Arithmetic wraps at N bits, so the most negative value still comes out exact.
          case (digit)
            2'b01:   acc_d = acc_q + weight;
            2'b11:   acc_d = acc_q - weight;
            2'b10:   error_d = 1'b1;
            default: acc_d = acc_q;
          endcase
          idx_d = idx_q + IW'(1);
          if (last_digit) begin
            state_d = S_DONE;
            idx_d   = '0;
          end
        end
      end
      S_DONE: begin
        if (result_ack) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      acc_q   <= '0;
      idx_q   <= '0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      idx_q   <= idx_d;
      error_q <= error_d;
    end
  end

  assign digit_ready  = (state_q == S_COLLECT);
  assign result_valid = (state_q == S_DONE);
  assign busy         = (state_q != S_IDLE);
  assign result       = acc_q;
  assign error        = error_q;

endmodule

// File: tb/tb_booth_digit_decoder.sv
// Randomized self-checking bench for booth_digit_decoder at N=4 and N=8.
module tb_booth_digit_decoder;

  logic       clk = 1'b0;
  logic       rst, start, digit_valid, result_ack;
  logic [1:0] digit;

  logic       rdy4, rv4, err4, busy4;
  logic [3:0] res4;
  logic       rdy8, rv8, err8, busy8;
  logic [7:0] res8;

  int n_checks = 0;
  int n_errors = 0;

  logic [1:0] dq[$];

  always #5 clk = ~clk;

  booth_digit_decoder #(.N(4)) dut4 (
    .clk(clk), .rst(rst), .start(start), .digit_valid(digit_valid), .digit(digit),
    .digit_ready(rdy4), .result(res4), .result_valid(rv4), .result_ack(result_ack),
    .error(err4), .busy(busy4)
  );

  booth_digit_decoder #(.N(8)) dut8 (
    .clk(clk), .rst(rst), .start(start), .digit_valid(digit_valid), .digit(digit),
    .digit_ready(rdy8), .result(res8), .result_valid(rv8), .result_ack(result_ack),
    .error(err8), .busy(busy8)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] o_res(input int w);
    return (w == 4) ? {4'b0, res4} : res8;
  endfunction

  // {busy, digit_ready, result_valid, error}
  function automatic logic [3:0] o_flags(input int w);
    return (w == 4) ? {busy4, rdy4, rv4, err4} : {busy8, rdy8, rv8, err8};
  endfunction

  // Reference: signed sum of d_k * 2^k, reduced modulo 2^w; any 10 digit flags an error.
  task automatic model(input int w, output logic [7:0] r, output logic e);
    int s;
    s = 0;
    e = 1'b0;
    for (int k = 0; k < dq.size(); k++) begin
      case (dq[k])
        2'b01: s += (1 << k);
        2'b11: s -= (1 << k);
        2'b10: e = 1'b1;
        default: ;
      endcase
    end
    r = 8'(s & ((1 << w) - 1));
  endtask

  task automatic booth(input logic [7:0] x, input int w);
    int prev, cur, d;
    dq.delete();
    prev = 0;
    for (int k = 0; k < w; k++) begin
      cur = int'(x[k]);
      d = prev - cur;
      dq.push_back(d == 1 ? 2'b01 : (d == -1 ? 2'b11 : 2'b00));
      prev = cur;
    end
  endtask

  task automatic begin_word(input int w, input string tag);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk({tag, ".start_flags"}, 32'(o_flags(w)), 32'(4'b1100));
  endtask

  task automatic feed(input int w, input int max_gap, input string tag);
    for (int k = 0; k < dq.size(); k++) begin
      repeat ($urandom_range(max_gap, 0)) begin
        digit_valid = 1'b0;
        digit       = 2'($urandom);
        start       = 1'($urandom);
        result_ack  = 1'($urandom);
        tick();
        chk({tag, ".gap_rdy"}, 32'(o_flags(w) >> 1), 32'(3'b110));
      end
      start       = 1'b0;
      result_ack  = 1'b0;
      digit_valid = 1'b1;
      digit       = dq[k];
      chk({tag, ".pre_accept"}, 32'(o_flags(w) >> 1), 32'(3'b110));
      tick();
    end
    digit_valid = 1'b0;
    digit       = 2'b00;
  endtask

  task automatic run_word(input int w, input int max_gap, input string tag);
    logic [7:0] er;
    logic       ee;
    model(w, er, ee);
    begin_word(w, tag);
    feed(w, max_gap, tag);
    chk({tag, ".done_flags"}, 32'(o_flags(w)), 32'({3'b101, ee}));
    chk({tag, ".result"}, 32'(o_res(w)), 32'(er));
  endtask

  task automatic ack_word(input int w, input string tag);
    logic [7:0] er;
    logic       ee;
    model(w, er, ee);
    result_ack = 1'b1;
    tick();
    result_ack = 1'b0;
    chk({tag, ".idle_flags"}, 32'(o_flags(w)), 32'({3'b000, ee}));
    chk({tag, ".held_result"}, 32'(o_res(w)), 32'(er));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    logic [7:0] x;
    logic [7:0] er;
    logic       ee;

    rst = 1'b1; start = 1'b0; digit_valid = 1'b0; digit = 2'b00; result_ack = 1'b0;
    // Reset wins over a simultaneous start.
    start = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    start = 1'b0;
    chk("reset.flags8", 32'(o_flags(8)), 0);
    chk("reset.res8", 32'(o_res(8)), 0);
    chk("reset.flags4", 32'(o_flags(4)), 0);

    // Digits offered in IDLE are ignored.
    digit_valid = 1'b1; digit = 2'b01;
    tick();
    tick();
    digit_valid = 1'b0;
    chk("idle_ignore.flags", 32'(o_flags(8)), 0);
    chk("idle_ignore.res", 32'(o_res(8)), 0);
    result_ack = 1'b1;
    tick();
    result_ack = 1'b0;
    chk("idle_ack.flags", 32'(o_flags(8)), 0);

    // N=4 directed word.
    dq = '{2'b00, 2'b00, 2'b11, 2'b00};
    run_word(4, 0, "n4");
    chk("n4.exact", 32'(res4), 32'(4'b1100));
    ack_word(4, "n4");
    do_reset();

    dq = '{2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01};
    run_word(8, 0, "h7f");
    chk("h7f.exact", 32'(res8), 32'h7F);
    ack_word(8, "h7f");

    dq = '{2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b11};
    run_word(8, 0, "h80");
    chk("h80.exact", 32'(res8), 32'h80);
    ack_word(8, "h80");

    booth(8'hA5, 8);
    run_word(8, 3, "a5_gaps");
    chk("a5.exact", 32'(res8), 32'hA5);
    ack_word(8, "a5_gaps");

    // Illegal digit: counted as zero, error sticky until the next start.
    dq = '{2'b00, 2'b00, 2'b00, 2'b10, 2'b00, 2'b00, 2'b00, 2'b00};
    run_word(8, 1, "illegal");
    repeat (3) tick();
    chk("illegal.err_held", 32'(o_flags(8)), 32'(4'b1011));
    chk("illegal.res_zero", 32'(res8), 0);
    ack_word(8, "illegal");
    tick();
    chk("illegal.err_after_ack", 32'(err8), 1);
    begin_word(8, "illegal_clear");

    // Abandon a word after 5 digits via reset.
    do_reset();
    booth(8'h5A, 8);
    dq = dq[0:4];
    begin_word(8, "abandon");
    feed(8, 0, "abandon");
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abandon.flags", 32'(o_flags(8)), 0);
    chk("abandon.res", 32'(o_res(8)), 0);
    repeat (3) tick();
    chk("abandon.no_valid", 32'(o_flags(8)), 0);

    booth(8'h3C, 8);
    run_word(8, 2, "after_abandon");
    for (int i = 0; i < 10; i++) begin
      start = (i == 4);
      tick();
      chk("hold.res", 32'(res8), 32'h3C);
      chk("hold.flags", 32'(o_flags(8)), 32'(4'b1010));
    end
    start = 1'b0;
    // start together with ack in DONE: return to IDLE only.
    start = 1'b1; result_ack = 1'b1;
    tick();
    start = 1'b0; result_ack = 1'b0;
    chk("start_ack.flags", 32'(o_flags(8)), 0);
    tick();
    chk("start_ack.stays_idle", 32'(o_flags(8)), 0);
    chk("start_ack.res_kept", 32'(res8), 32'h3C);

    // Random values through their Booth digits, including the extremes.
    for (int t = 0; t < 20; t++) begin
      x = (t == 0) ? 8'h80 : ((t == 1) ? 8'hFF : 8'($urandom));
      booth(x, 8);
      run_word(8, 2, "rand_booth");
      chk("rand_booth.exact", 32'(res8), 32'(x));
      ack_word(8, "rand_booth");
    end

    // Arbitrary raw digit streams, including illegal codes.
    for (int t = 0; t < 20; t++) begin
      dq.delete();
      for (int k = 0; k < 8; k++) dq.push_back(2'($urandom));
      run_word(8, 2, "rand_raw");
      ack_word(8, "rand_raw");
    end

    model(8, er, ee);
    chk("final.err_kept", 32'(err8), 32'(ee));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
